// File: rtl/sum_latch_uart_tx_if.sv
`timescale 1ns/1ps
// sum_latch_uart_tx_if
//   Bundles the operand-capture and UART-status signals of sum_latch_uart_tx.
//   master: drives the save strobes and the shared data bus, observes results.
//   slave : the datapath itself.
//   save_n      master->slave  NUM_OPS  active-low latch strobes (asynchronous)
//   data_input  master->slave  DATA_W   shared operand bus
//   sum_out     slave->master  SUM_W    last transmitted sum
//   op_valid    slave->master  NUM_OPS  latched-not-yet-consumed flags
//   uart_txd    slave->master  1        serial line, idle high
//   uart_tx_busy slave->master 1        frame in progress
interface sum_latch_uart_tx_if #(
  parameter int DATA_W  = 4,
  parameter int NUM_OPS = 2
);
  localparam int SUM_W = DATA_W + $clog2(NUM_OPS);

  logic [NUM_OPS-1:0] save_n;
  logic [DATA_W-1:0]  data_input;
  logic [SUM_W-1:0]   sum_out;
  logic [NUM_OPS-1:0] op_valid;
  logic               uart_txd;
  logic               uart_tx_busy;

  modport master (
    output save_n, data_input,
    input  sum_out, op_valid, uart_txd, uart_tx_busy
  );

  modport slave (
    input  save_n, data_input,
    output sum_out, op_valid, uart_txd, uart_tx_busy
  );
endinterface

// File: rtl/sum_latch_uart_tx.sv
`timescale 1ns/1ps
// sum_latch_uart_tx
//   Latches NUM_OPS operands from a shared bus on active-low save strobes, sums
//   them once every channel holds a value, and sends the SUM_W-bit sum over a
//   UART as NBYTES bytes, least significant byte first.
//
//   Optional feature macro: UART_PARITY_EN. When defined, an even-parity bit is
//   sent after D7 of every byte (8E1); otherwise frames are 8N1.
//
// Ports
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   bus        sum_latch_uart_tx_if.slave (save_n, data_input, sum_out,
//              op_valid, uart_txd, uart_tx_busy)
//   dbg_state  current FSM state (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4,
//              NEXT=5)
//
// Capture contract: op_valid[i] rises on the cycle channel i latches and falls
// only when a launch consumes the operand set. A launch happens in any IDLE
// cycle where every op_valid bit is set and consumes the whole set at once; a
// strobe edge seen in that same cycle wins and leaves its channel valid with
// the new value. There is no back-pressure on the strobes.
module sum_latch_uart_tx #(
  parameter int DATA_W       = 4,
  parameter int NUM_OPS      = 2,
  parameter int CLKS_PER_BIT = 104
) (
  input  logic                clk,
  input  logic                reset_n,
  sum_latch_uart_tx_if.slave  bus,
  output logic [2:0]          dbg_state
);
  localparam int SUM_W  = DATA_W + $clog2(NUM_OPS);
  localparam int NBYTES = (SUM_W + 7) / 8;
  localparam int BUF_W  = NBYTES * 8;
  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int BCNT_W = $clog2(NBYTES) + 1;
  localparam logic [CNT_W-1:0] TICK_RELOAD = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4, NEXT = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4, NEXT = 3'd5
  } state_t;
`endif

  // Strobe synchronisers: two metastability flops plus a history flop.
  logic [NUM_OPS-1:0] sync1, sync2, hist;
  logic [NUM_OPS-1:0] strobe_edge;
  logic [NUM_OPS-1:0] op_valid;
  logic [DATA_W-1:0]  op [NUM_OPS];
  logic [SUM_W-1:0]   sum_all;
  logic               launch;

  state_t             state;
  logic [BUF_W-1:0]   shift_buf;
  logic [CNT_W-1:0]   tick;
  logic [2:0]         bit_idx;
  logic [BCNT_W-1:0]  bytes_left;
  logic [SUM_W-1:0]   sum_q;
  logic               txd;
  logic               busy;
`ifdef UART_PARITY_EN
  logic               par;
`endif

  assign strobe_edge = hist & ~sync2;
  assign launch      = (state == IDLE) && (&op_valid);

  // Operands are DATA_W wide and SUM_W leaves room for NUM_OPS of them, so the
  // accumulation cannot overflow.
  always_comb begin
    sum_all = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      sum_all = sum_all + SUM_W'(op[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // Synchronisers rest high so an idle strobe never reads as an edge.
      sync1    <= '1;
      sync2    <= '1;
      hist     <= '1;
      op_valid <= '0;
      for (int i = 0; i < NUM_OPS; i++) begin
        op[i] <= '0;
      end
    end else begin
      sync1    <= bus.save_n;
      sync2    <= sync1;
      hist     <= sync2;
      op_valid <= (launch ? '0 : op_valid) | strobe_edge;
      for (int i = 0; i < NUM_OPS; i++) begin
        if (strobe_edge[i]) begin
          op[i] <= bus.data_input;
        end
      end
    end
  end

  // Transmit FSM. Every bit state lasts CLKS_PER_BIT cycles via a down-counter
  // reloaded on entry; NEXT is a single cycle between bytes (and after the last).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      shift_buf  <= '0;
      tick       <= '0;
      bit_idx    <= '0;
      bytes_left <= '0;
      sum_q      <= '0;
      txd        <= 1'b1;
      busy       <= 1'b0;
`ifdef UART_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            // The shift buffer holds a snapshot, so later strobes cannot
            // disturb the frame in flight. Upper pad bits go out as zeros.
            shift_buf  <= BUF_W'(sum_all);
            sum_q      <= sum_all;
            bytes_left <= BCNT_W'(NBYTES - 1);
            tick       <= TICK_RELOAD;
            txd        <= 1'b0;
            busy       <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          if (tick == '0) begin
            tick    <= TICK_RELOAD;
            bit_idx <= '0;
            txd     <= shift_buf[0];
`ifdef UART_PARITY_EN
            par     <= 1'b0;
`endif
            state   <= DATA;
          end else begin
            tick <= tick - 1'b1;
          end
        end
        DATA: begin
          if (tick == '0) begin
            tick      <= TICK_RELOAD;
            shift_buf <= shift_buf >> 1;
`ifdef UART_PARITY_EN
            par       <= par ^ txd;
`endif
            if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
              txd   <= par ^ txd;
              state <= PARITY;
`else
              txd   <= 1'b1;
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
              txd     <= shift_buf[1];
            end
          end else begin
            tick <= tick - 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (tick == '0) begin
            tick  <= TICK_RELOAD;
            txd   <= 1'b1;
            state <= STOP;
          end else begin
            tick <= tick - 1'b1;
          end
        end
`endif
        STOP: begin
          if (tick == '0) begin
            txd   <= 1'b1;
            state <= NEXT;
          end else begin
            tick <= tick - 1'b1;
          end
        end
        NEXT: begin
          if (bytes_left != '0) begin
            bytes_left <= bytes_left - 1'b1;
            tick       <= TICK_RELOAD;
            txd        <= 1'b0;
            state      <= START;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          txd   <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.sum_out      = sum_q;
  assign bus.op_valid     = op_valid;
  assign bus.uart_txd     = txd;
  assign bus.uart_tx_busy = busy;
  assign dbg_state        = state;
endmodule
